// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat FSM encoding,
// button index names for the game logic, and a small sizing helper.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_e;

    // Bit positions of the board buttons in every N_BTN-wide vector.
    localparam int BTN_U = 0;
    localparam int BTN_S = 1;
    localparam int BTN_D = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: two-flop synchronizer, counting debouncer,
// registered press/release pulses and an optional auto-repeat FSM.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 50000000,
    parameter int REPEAT_RATE_CYCLES  = 10000000,
    parameter bit REPEAT_EN           = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Next-state logic for synchronizer, debounce counter and edge pulses.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        s1_d     = btn_raw;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        // Pulses are registered alongside the level, so they cover exactly
        // the first cycle of the new level.
        press_d   = stable_d & ~stable_q;
        release_d = ~stable_d & stable_q;
    end

    // State registers for synchronizer, debouncer and pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

    if (REPEAT_EN) begin : g_repeat
        localparam int TW = $clog2(max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES) + 1);
        localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYCLES);
        localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_CYCLES);
        localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

        rep_state_e    state_q;
        logic [TW-1:0] timer_q;
        logic          rep_q;

        // Auto-repeat FSM; looks at the level being registered this edge so a
        // release always beats a coinciding timer expiry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                timer_q <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (press_d) begin
                            rep_q   <= 1'b1;
                            state_q <= DELAY;
                            timer_q <= TIMER_ONE;
                        end
                    end
                    DELAY: begin
                        if (!stable_d) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                        end else if (timer_q == DELAY_LAST) begin
                            rep_q   <= 1'b1;
                            state_q <= REPEAT;
                            timer_q <= TIMER_ONE;
                        end else begin
                            timer_q <= timer_q + TIMER_ONE;
                        end
                    end
                    REPEAT: begin
                        if (!stable_d) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                        end else if (timer_q == RATE_LAST) begin
                            rep_q   <= 1'b1;
                            timer_q <= TIMER_ONE;
                        end else begin
                            timer_q <= timer_q + TIMER_ONE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                    end
                endcase
            end
        end

        assign btn_repeat = rep_q;
    end else begin : g_no_repeat
        assign btn_repeat = press_q;
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons for the game logic: one independent
// btn_channel per button, all in the main clk domain.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               N_BTN               = 3,
    parameter int               DEBOUNCE_CYCLES     = 1000000,
    parameter int               REPEAT_DELAY_CYCLES = 50000000,
    parameter int               REPEAT_RATE_CYCLES  = 10000000,
    parameter logic [N_BTN-1:0] REPEAT_EN           = 3'b101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
            .REPEAT_EN          (REPEAT_EN[i])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared every cycle against a window-based reference model.
module tb_button_conditioner;

    localparam int         N    = 3;
    localparam int         DEB  = 4;
    localparam int         DLY  = 10;
    localparam int         RATE = 3;
    localparam logic [2:0] REN  = 3'b101;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [2:0] btn_level, btn_press, btn_release, btn_repeat;

    button_conditioner #(
        .N_BTN              (N),
        .DEBOUNCE_CYCLES    (DEB),
        .REPEAT_DELAY_CYCLES(DLY),
        .REPEAT_RATE_CYCLES (RATE),
        .REPEAT_EN          (REN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: raw sample taken at each edge since reset release.
    int         e;
    logic [2:0] raw_hist [0:4095];
    logic [2:0] m_level, m_press, m_release, m_repeat;
    int         t0 [3];

    // Observed activity, used by the directed checks.
    int last_press [3];
    int last_rel   [3];
    int last_rep   [3];
    int press_cnt  [3];
    int rep_cnt    [3];

    // Value the debouncer compares at edge idx: raw as sampled two edges earlier.
    function automatic logic syn(input int ch, input int idx);
        if (idx < 2) return 1'b0;
        return raw_hist[idx-2][ch];
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b edge=%0d", tag, obs, exp, e);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e         = -1;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_repeat  = '0;
        for (int c = 0; c < N; c++) t0[c] = 0;
    endtask

    task automatic clear_obs();
        for (int c = 0; c < N; c++) begin
            last_press[c] = -1000;
            last_rel[c]   = -1000;
            last_rep[c]   = -1000;
            press_cnt[c]  = 0;
            rep_cnt[c]    = 0;
        end
    endtask

    // Level flips once the synchronized input has disagreed with it for the
    // last DEB edges; repeat pulses follow the t0 / +DLY / +RATE schedule.
    task automatic model_edge();
        logic flip, prev;
        int   k;
        e++;
        raw_hist[e] = btn_raw;
        for (int c = 0; c < N; c++) begin
            prev = m_level[c];
            flip = (e - DEB + 1 >= 0);
            for (int j = 0; j < DEB; j++) begin
                if (e - j >= 0 && syn(c, e - j) == prev) flip = 1'b0;
            end
            m_press[c]   = flip && !prev;
            m_release[c] = flip && prev;
            if (flip) m_level[c] = !prev;
            if (m_press[c]) t0[c] = e;
            if (REN[c]) begin
                k = e - t0[c];
                m_repeat[c] = m_level[c] &&
                              (k == 0 || k == DLY || (k > DLY && (k - DLY) % RATE == 0));
            end else begin
                m_repeat[c] = m_press[c];
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level",   btn_level,   m_level);
        check("press",   btn_press,   m_press);
        check("release", btn_release, m_release);
        check("repeat",  btn_repeat,  m_repeat);
        for (int c = 0; c < N; c++) begin
            if (btn_press[c])   begin last_press[c] = e; press_cnt[c]++; end
            if (btn_release[c]) last_rel[c] = e;
            if (btn_repeat[c])  begin last_rep[c] = e; rep_cnt[c]++; end
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int start;

        // Reset state.
        rst     = 1'b1;
        btn_raw = '0;
        model_reset();
        clear_obs();
        @(negedge clk);
        @(negedge clk);
        check("rst_level",   btn_level,   3'b000);
        check("rst_press",   btn_press,   3'b000);
        check("rst_release", btn_release, 3'b000);
        check("rst_repeat",  btn_repeat,  3'b000);
        rst = 1'b0;
        hold(4);

        // Clean press on btnU with auto-repeat, released so level falls at t0+14.
        clear_obs();
        start = e + 1;
        btn_raw[0] = 1'b1;
        hold(14);
        btn_raw[0] = 1'b0;
        hold(20);
        check_int("clean_press_latency", last_press[0] - start, 5);
        check_int("u_repeat_count", rep_cnt[0], 3);
        check_int("u_last_repeat", last_rep[0] - start, 5 + 13);
        check_int("u_release_latency", last_rel[0] - start, 5 + 14);

        // Bounce on btnD: short pulses ignored, final rise accepted.
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            btn_raw[2] = ~i[0];
            hold(2);
        end
        for (int i = 0; i < 4; i++) begin
            btn_raw[2] = ~i[0];
            if (i == 2) start = e + 1;
            hold(2);
        end
        btn_raw[2] = 1'b1;
        start = e + 1;
        hold(20);
        check_int("bounce_press_count", press_cnt[2], 1);
        check_int("bounce_press_latency", last_press[2] - start, 5);
        btn_raw[2] = 1'b0;
        hold(12);

        // btnS has no auto-repeat: one repeat pulse, at the press.
        clear_obs();
        btn_raw[1] = 1'b1;
        hold(40);
        btn_raw[1] = 1'b0;
        start = e + 1;
        hold(10);
        check_int("s_repeat_count", rep_cnt[1], 1);
        check_int("s_repeat_at_press", last_rep[1], last_press[1]);
        check_int("s_release_latency", last_rel[1] - start, 5);

        // Simultaneous press on all channels.
        clear_obs();
        start = e + 1;
        btn_raw = 3'b111;
        hold(20);
        for (int c = 0; c < N; c++) check_int("simul_press", last_press[c] - start, 5);
        btn_raw = 3'b000;
        hold(10);

        // Random activity: mix of bounces and holds on every channel.
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            end
            cycle();
        end
        btn_raw = '0;
        hold(10);

        // Reset while btnU is held and repeating.
        clear_obs();
        btn_raw[0] = 1'b1;
        hold(20);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_level",   btn_level,   3'b000);
        check("midrst_press",   btn_press,   3'b000);
        check("midrst_release", btn_release, 3'b000);
        check("midrst_repeat",  btn_repeat,  3'b000);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst_hold_level", btn_level, 3'b000);
        rst = 1'b0;
        model_reset();
        clear_obs();
        hold(12);
        check_int("post_rst_press_edge", last_press[0], 5);
        btn_raw = '0;
        hold(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
